// File: rtl/key_pkg.sv
//------------------------------------------------------------------------------
// key_pkg
// Shared constants, channel state type and counter-width helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package key_pkg;

  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD_WAIT = 2'd1,
    REPEATING = 2'd2
  } key_state_t;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
//------------------------------------------------------------------------------
// key_channel
// One pushbutton: 2-flop synchronizer, debouncer, press/release/repeat pulses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 128,
  parameter int REPEAT_DELAY    = 12207,
  parameter int REPEAT_PERIOD   = 2441,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_held,
  output logic o_press,
  output logic o_release
);

  localparam int c_DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int c_RP_W = (cnt_w(REPEAT_DELAY) > cnt_w(REPEAT_PERIOD)) ?
                          cnt_w(REPEAT_DELAY) : cnt_w(REPEAT_PERIOD);
  localparam logic [c_DB_W-1:0] c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RP_W-1:0] c_DELAY_LAST = c_RP_W'(REPEAT_DELAY - 1);
  localparam logic [c_RP_W-1:0] c_PER_LAST   = c_RP_W'(REPEAT_PERIOD - 1);

  logic              r_sync1, r_sync2;
  key_state_t        r_state, w_state_nxt;
  logic [c_DB_W-1:0] r_db_cnt, w_db_nxt;
  logic [c_RP_W-1:0] r_rep_cnt, w_rep_nxt;
  logic              r_press, w_press_nxt;
  logic              r_release, w_release_nxt;
  logic              w_stable;
  logic              w_flip;

  // The state encodes the debounced level: any non-IDLE state means pressed.
  assign w_stable = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= IDLE;
      r_db_cnt  <= '0;
      r_rep_cnt <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= ~i_key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_db_cnt  <= w_db_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_db_nxt      = r_db_cnt;
    w_rep_nxt     = r_rep_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_flip        = 1'b0;

    if (r_sync2 == w_stable) begin
      w_db_nxt = '0;
    end else if (r_db_cnt == c_DB_LAST) begin
      w_db_nxt = '0;
      w_flip   = 1'b1;
    end else begin
      w_db_nxt = r_db_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_flip) begin
          w_state_nxt = HELD_WAIT;
          w_rep_nxt   = '0;
          w_press_nxt = 1'b1;
        end
      end
      HELD_WAIT, REPEATING: begin
        // A release wins over a coincident repeat terminal count.
        if (w_flip) begin
          w_state_nxt   = IDLE;
          w_rep_nxt     = '0;
          w_release_nxt = 1'b1;
        end else if (REPEAT_EN) begin
          if (r_rep_cnt == ((r_state == HELD_WAIT) ? c_DELAY_LAST : c_PER_LAST)) begin
            w_state_nxt = REPEATING;
            w_rep_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_rep_nxt = r_rep_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_held    = w_stable;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
//------------------------------------------------------------------------------
// key_conditioner
// Four independent pushbutton conditioning channels for the game controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_conditioner
  import key_pkg::*;
#(
  parameter int                   DEBOUNCE_CYCLES = 128,
  parameter int                   REPEAT_DELAY    = 12207,
  parameter int                   REPEAT_PERIOD   = 2441,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_key_n   (KEY[i]),
      .o_held    (held[i]),
      .o_press   (press[i]),
      .o_release (release_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
//------------------------------------------------------------------------------
// tb_key_conditioner
// Random and scenario stimulus against a timing-rule reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_conditioner;

  localparam int         c_DB   = 4;
  localparam int         c_DLY  = 10;
  localparam int         c_PER  = 3;
  localparam logic [3:0] c_MASK = 4'b0100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [3:0] held, press, release_pulse;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  bit started = 1'b0;

  key_conditioner #(
    .DEBOUNCE_CYCLES (c_DB),
    .REPEAT_DELAY    (c_DLY),
    .REPEAT_PERIOD   (c_PER),
    .REPEAT_MASK     (c_MASK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .KEY           (KEY),
    .held          (held),
    .press         (press),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  // Reference: level accepted once the last c_DB synchronized samples all
  // disagree with it; repeats fall at T+DELAY, T+DELAY+k*PERIOD while held.
  bit m_s1[4], m_s2[4], m_st[4];
  int m_tp[4];
  bit m_win[4][$];
  int cyc = 0;

  task automatic model_step();
    logic [3:0] eh, ep, er;
    bit diff;
    int e;
    eh = '0; ep = '0; er = '0;
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_s1[k] = 0; m_s2[k] = 0; m_st[k] = 0;
        m_win[k].delete();
      end else begin
        m_win[k].push_back(m_s2[k]);
        if (m_win[k].size() > c_DB) void'(m_win[k].pop_front());
        diff = (m_win[k].size() == c_DB);
        foreach (m_win[k][j]) if (m_win[k][j] == m_st[k]) diff = 0;
        m_s2[k] = m_s1[k];
        m_s1[k] = !KEY[k];
        if (diff) begin
          m_st[k] = !m_st[k];
          if (m_st[k]) begin ep[k] = 1'b1; m_tp[k] = cyc; end
          else er[k] = 1'b1;
        end else if (m_st[k] && c_MASK[k]) begin
          e = cyc - m_tp[k];
          if (e == c_DLY || (e > c_DLY && (e - c_DLY) % c_PER == 0)) ep[k] = 1'b1;
        end
        eh[k] = m_st[k];
      end
    end
    exp_q.push_back({eh, ep, er});
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1'b1;
  end

  // Monitor: compare DUT outputs away from the active edge.
  initial forever begin
    logic [11:0] exp_v, act_v;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {held, press, release_pulse};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        if (failures <= 20)
          $display("FAIL outputs t=%0t: got held=%b press=%b release=%b, expected held=%b press=%b release=%b",
                   $time, act_v[11:8], act_v[7:4], act_v[3:0], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
      end
    end else if (started) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expected entry at t=%0t", $time);
    end
  end

  task automatic drive(input logic [3:0] k, input int n);
    KEY = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] kv;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(4'hF, 3);
    // Clean press and release on key 0
    drive(4'b1110, 12);
    drive(4'hF, 12);
    // Bounce on key 1
    drive(4'b1101, 3);
    drive(4'hF, 1);
    drive(4'b1101, 10);
    drive(4'hF, 10);
    // Auto-repeat on key 2, none on key 3
    drive(4'b0011, 50);
    drive(4'hF, 10);
    // Reset mid-hold
    drive(4'b1110, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1110, 12);
    drive(4'hF, 10);
    // Simultaneous press on keys 0 and 3
    drive(4'b0110, 10);
    drive(4'hF, 10);
    // Random: bouncy phase then long-hold phase
    kv = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, (n < 1500) ? 5 : 39) == 0) kv[k] = ~kv[k];
      reset = ($urandom_range(0, 299) == 0);
      drive(kv, 1);
    end
    reset = 1'b0;
    drive(4'hF, 20);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_conditioner.md
# key_conditioner

Conditions the four active-low DE1-SoC pushbuttons before they reach the mastermind game logic. The block sits between the top-level `KEY` pins and the game controller, in the divided `clk` domain. For each key it provides:
- a two-flop synchronizer;
- a counter-based debouncer;
- a debounced level output;
- one-cycle press and release pulses, with optional auto-repeat.

The game controller then reacts exactly once per physical press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 128: consecutive stable cycles required to accept a level change (≈5 ms at the 24.4 kHz game clock). Must be ≥1.
- `REPEAT_DELAY`, 12207: cycles from press until the first auto-repeat pulse (≈0.5 s). Must be ≥1.
- `REPEAT_PERIOD`, 2441: cycles between later auto-repeat pulses (≈0.1 s). Must be ≥1.
- `REPEAT_MASK`, 4'b0000: bit i = 1 enables auto-repeat on key i.

Ports:
- `clk`, input, 1: game clock (divided clock selected at top level).
- `reset`, input, 1: synchronous, active-high.
- `KEY`, input, 4: raw pushbuttons, 0 = pressed, asynchronous to `clk`.
- `held`, output, 4: debounced level, 1 = pressed.
- `press`, output, 4: one-cycle pulse on debounced press and on each auto-repeat.
- `release`, output, 4: one-cycle pulse on debounced release.

## Operation
- The four channels are identical and independent. Each channel holds:
  - `sync1`, `sync2`: synchronizer flops, storing the inverted KEY (1 = pressed);
  - `stable`: drives `held`;
  - `db_cnt`: debounce counter;
  - `rep_cnt`: repeat counter;
  - `rep_first`: flag indicating the first repeat interval has not yet elapsed.
- On reset, all flops clear:
  - `sync1` = `sync2` = 0 (not pressed), `stable` = 0, both counters 0, `rep_first` = 1;
  - `held`, `press` and `release` all read 0.
- Debounce, evaluated each cycle:
  - If `sync2` == `stable`, `db_cnt` ← 0.
  - Otherwise, if `db_cnt` == `DEBOUNCE_CYCLES`-1: `stable` ← `sync2`, `db_cnt` ← 0.
  - Otherwise, `db_cnt` increments.
  - Any bounce back to `stable` restarts the count.
- Pulses are registered:
  - `press` = 1 in the cycle following the update in which `stable` goes 0→1.
  - `release` = 1 in the cycle following the update in which `stable` goes 1→0.
- Auto-repeat (only if `REPEAT_MASK[i]`):
  - On `stable` 0→1: `rep_cnt` ← 0, `rep_first` ← 1.
  - While `stable` = 1, `rep_cnt` increments each cycle.
  - When `rep_cnt` reaches `REPEAT_DELAY`-1 (if `rep_first`) or `REPEAT_PERIOD`-1 (otherwise): `press` pulses next cycle, `rep_cnt` ← 0, `rep_first` ← 0.
  - `stable` 1→0 stops repeating immediately; no repeat pulse coincides with the `release` pulse.
- Per-channel FSM, encoded by (`stable`, `rep_first`): IDLE (0,x), HELD_WAIT (1,1), REPEATING (1,0).
  - IDLE → HELD_WAIT on debounced press.
  - HELD_WAIT → REPEATING on first repeat.
  - Any held state → IDLE on debounced release.
  - With `REPEAT_MASK[i]` = 0, the channel never leaves HELD_WAIT while held.
- Counter widths are `$clog2` of the parameter value. Counters never wrap, because they are cleared at terminal count.

## Timing
- Edge 0 is the first edge at which KEY[i] = 0 is sampled.
  - `sync2` = 1 after edge 1.
  - `stable`/`held` = 1 after edge `DEBOUNCE_CYCLES`+1.
  - `press` = 1 during the cycle after edge `DEBOUNCE_CYCLES`+1, for exactly one cycle.
- Release latency is the same, measured from the first sampled KEY = 1.
- Auto-repeat pulses occur at T+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles, where T is the cycle of the initial press pulse.
- Simultaneous events on different keys are independent; multiple `press` bits may be high in the same cycle.
- Reset asserted mid-press:
  - outputs are 0 on the cycle after the reset edge;
  - after reset deasserts with the key still down, a full new debounce runs and a fresh `press` pulse is issued.
- Bounce handling: a glitch shorter than `DEBOUNCE_CYCLES` produces no change in `held` and no pulse.

## Structure
- Package `key_pkg`:
  - `localparam NUM_KEYS = 4`;
  - `typedef enum logic [1:0] {IDLE, HELD_WAIT, REPEATING} key_state_t`, for debug visibility.
- Sub-module `key_channel`: one channel, with the same parameters plus a scalar `REPEAT_EN`.
- `key_conditioner` instantiates four `key_channel`s in a generate loop, passing `REPEAT_MASK[i]`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: hold KEY[0] = 0 from edge 0 → `held[0]` rises after edge 5, `press[0]` high one cycle, `release[0]` never asserts while held.
- Bounce: KEY[1] low 3 cycles, high 1 cycle, low steady → no pulse until 4 consecutive low cycles after the bounce, then exactly one `press[1]`.
- Release: release KEY[0] after `held` → `held[0]` falls 5 edges later, `release[0]` one cycle, `press[0]` stays 0.
- Auto-repeat with `REPEAT_MASK` = 4'b0100, KEY[2] held 30 cycles past its press pulse → `press[2]` at T, T+10, T+13, T+16, …; KEY[3], held identically, produces only one pulse.
- Reset mid-hold: assert `reset` while `held[0]` = 1 with the key still down → all outputs 0 the next cycle; after deassert, `press[0]` fires again 6 cycles later.
- Simultaneous: KEY[0] and KEY[3] pressed on the same edge → `press` = 4'b1001 in a single cycle.
